baggage_drop_seq: RTL and testbench

- Clocked, parametrised successor to the combinational baggage-drop datapath.
- On a start handshake it samples N height sensors and averages the non-zero readings with rounding, using an iterative divider.
- It then computes fall time t_act = sqrt(height)/2 in fixed point with an iterative square root, and compares it against t_lim.
- It drives drop_activated and a 4-digit "drOP"/"CoLd"/"----" seven-segment message, with a done pulse and held results for the system controller.

---
 rtl/baggage_drop_seq.sv | 136 +++++++++++++
 tb/tb_baggage_drop_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/baggage_drop_seq.sv
// baggage_drop_seq: sequential sensor-average, sqrt fall-time and drop/cold decision with 7-seg message
module baggage_drop_seq #(
  parameter int N_SENSORS = 4,
  parameter int SENSOR_W  = 8,
  parameter int FRAC      = 8,
  parameter int T_W       = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [N_SENSORS*SENSOR_W-1:0]   sensors,
  input  logic [T_W-1:0]                  t_lim,
  input  logic                            drop_en,
  output logic                            busy,
  output logic                            done,
  output logic                            fault,
  output logic [SENSOR_W-1:0]             height,
  output logic [T_W-1:0]                  t_act,
  output logic                            drop_activated,
  output logic [6:0]                      seven_seg1,
  output logic [6:0]                      seven_seg2,
  output logic [6:0]                      seven_seg3,
  output logic [6:0]                      seven_seg4
);
  localparam int SW = SENSOR_W + $clog2(N_SENSORS);
  localparam int RW = SENSOR_W / 2 + FRAC;
  localparam int KW = $clog2(N_SENSORS + 1);
  localparam int CW = $clog2(N_SENSORS + SW + RW + 1);
  localparam logic [27:0] MSG_DROP = {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011};
  localparam logic [27:0] MSG_COLD = {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110};
  localparam logic [27:0] MSG_DASH = {4{7'b1000000}};
  typedef enum logic [2:0] {IDLE, SUM, DIV, SQRT, CMP, FAULT} state_t;
  state_t state, state_n;
  logic [N_SENSORS*SENSOR_W-1:0] sens_l;
  logic [T_W-1:0] t_lim_l, t_n;
  logic drop_en_l, drop_n, ge, last;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sum, sum_n, dq, dq_n, rem, rem_n;
  logic [SW:0] rs;
  logic [KW-1:0] k, k_n;
  logic [SENSOR_W-1:0] s;
  logic [2*RW-1:0] rad;
  logic [RW+3:0] r, r_n;
  logic [RW-1:0] sq;
  assign busy = state != IDLE;
  always_comb begin
    s = sens_l[int'(cnt)*SENSOR_W +: SENSOR_W];
    sum_n = sum + SW'(s);
    k_n = k + KW'(s != '0);
    rs = {rem, dq[SW-1]};
    ge = rs >= (SW+1)'(k);
    rem_n = SW'(ge ? rs - (SW+1)'(k) : rs);
    dq_n = {dq[SW-2:0], ge};
    // non-restoring root step: sign of the partial remainder picks add or subtract
    r_n = r[RW+3] ? (RW+4)'({r, rad[2*RW-1 -: 2]}) + {2'b00, sq, 2'b11}
                  : (RW+4)'({r, rad[2*RW-1 -: 2]}) - {2'b00, sq, 2'b01};
    t_n = T_W'(sq[RW-1:1]);
    drop_n = drop_en_l && (t_n <= t_lim_l);
    last = cnt == (state == SUM ? CW'(N_SENSORS - 1) : state == DIV ? CW'(SW - 1) : CW'(RW - 1));
    state_n = state == IDLE ? (start ? SUM : IDLE)
            : state == SUM  ? (last ? (k_n == '0 ? FAULT : DIV) : SUM)
            : state == DIV  ? (last ? SQRT : DIV)
            : state == SQRT ? (last ? CMP : SQRT)
            : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      fault <= 1'b0;
      height <= '0;
      t_act <= '0;
      drop_activated <= 1'b0;
      {seven_seg1, seven_seg2, seven_seg3, seven_seg4} <= '0;
      sens_l <= '0;
      t_lim_l <= '0;
      drop_en_l <= 1'b0;
      cnt <= '0;
      sum <= '0;
      k <= '0;
      dq <= '0;
      rem <= '0;
      rad <= '0;
      r <= '0;
      sq <= '0;
    end else begin
      done <= state == CMP || state == FAULT;
      cnt <= state_n != state ? '0 : cnt + CW'(1);
      case (state)
        IDLE: if (start) begin
          sens_l <= sensors;
          t_lim_l <= t_lim;
          drop_en_l <= drop_en;
          fault <= 1'b0;
          height <= '0;
          t_act <= '0;
          drop_activated <= 1'b0;
          {seven_seg1, seven_seg2, seven_seg3, seven_seg4} <= '0;
          sum <= '0;
          k <= '0;
        end
        SUM: begin
          sum <= sum_n;
          k <= k_n;
          dq <= sum_n + SW'(k_n >> 1);
          rem <= '0;
        end
        DIV: begin
          dq <= dq_n;
          rem <= rem_n;
          rad <= {dq_n[SENSOR_W-1:0], {(2*FRAC){1'b0}}};
          r <= '0;
          sq <= '0;
          if (last) height <= dq_n[SENSOR_W-1:0];
        end
        SQRT: begin
          r <= r_n;
          sq <= {sq[RW-2:0], ~r_n[RW+3]};
          rad <= rad << 2;
        end
        CMP: begin
          t_act <= t_n;
          drop_activated <= drop_n;
          {seven_seg1, seven_seg2, seven_seg3, seven_seg4} <= drop_n ? MSG_DROP : MSG_COLD;
        end
        FAULT: begin
          fault <= 1'b1;
          {seven_seg1, seven_seg2, seven_seg3, seven_seg4} <= MSG_DASH;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_baggage_drop_seq.sv
// tb_baggage_drop_seq: randomized and directed checks of baggage_drop_seq against an arithmetic reference model
module tb_baggage_drop_seq;
  logic clk = 0, rst_n = 0, start = 0, drop_en = 0;
  logic [31:0] sensors = '0;
  logic [15:0] t_lim = '0;
  logic busy, done, fault, drop_activated;
  logic [7:0] height;
  logic [15:0] t_act;
  logic [6:0] seven_seg1, seven_seg2, seven_seg3, seven_seg4;
  int errors = 0, checks = 0;
  localparam logic [27:0] DROP = {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011};
  localparam logic [27:0] COLD = {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110};
  localparam logic [27:0] DASH = {4{7'b1000000}};
  always #5 clk = ~clk;
  baggage_drop_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sensors(sensors), .t_lim(t_lim), .drop_en(drop_en),
    .busy(busy), .done(done), .fault(fault), .height(height), .t_act(t_act),
    .drop_activated(drop_activated), .seven_seg1(seven_seg1), .seven_seg2(seven_seg2),
    .seven_seg3(seven_seg3), .seven_seg4(seven_seg4)
  );
  function automatic void model(input logic [31:0] sv, input logic [15:0] tl, input logic en,
                                output logic f, output int h, output int t, output logic d,
                                output logic [27:0] seg, output int lat);
    int sum = 0, k = 0;
    longint v, root = 0;
    for (int i = 0; i < 4; i++) begin
      int x = int'(sv[i*8 +: 8]);
      if (x != 0) begin sum += x; k++; end
    end
    f = k == 0;
    h = f ? 0 : (sum + k / 2) / k;
    v = longint'(h) * 65536;
    while ((root + 1) * (root + 1) <= v) root++;
    t = f ? 0 : int'(root / 2);
    d = !f && en && (t <= int'(tl));
    seg = f ? DASH : d ? DROP : COLD;
    lat = f ? 5 : 27;
  endfunction
  task automatic run_case(input string name, input logic [31:0] sv, input logic [15:0] tl, input logic en);
    logic ef, ed;
    int eh, et, elat, lat;
    logic [27:0] eseg;
    model(sv, tl, en, ef, eh, et, ed, eseg, elat);
    @(negedge clk);
    sensors = sv; t_lim = tl; drop_en = en; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0; lat = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1", name, busy); end
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    checks++; if (lat !== elat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, elat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
    checks++; if (fault !== ef) begin errors++; $display("FAIL %s fault: got %b want %b", name, fault, ef); end
    checks++; if (int'(height) !== eh) begin errors++; $display("FAIL %s height: got %0d want %0d", name, height, eh); end
    checks++; if (int'(t_act) !== et) begin errors++; $display("FAIL %s t_act: got %0d want %0d", name, t_act, et); end
    checks++; if (drop_activated !== ed) begin errors++; $display("FAIL %s drop: got %b want %b", name, drop_activated, ed); end
    checks++;
    if ({seven_seg1, seven_seg2, seven_seg3, seven_seg4} !== eseg) begin
      errors++; $display("FAIL %s segs: got %h want %h", name, {seven_seg1, seven_seg2, seven_seg3, seven_seg4}, eseg);
    end
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse: got %b want 0", name, done); end
    checks++; if (int'(t_act) !== et || int'(height) !== eh) begin
      errors++; $display("FAIL %s hold: got %0d/%0d want %0d/%0d", name, height, t_act, eh, et);
    end
  endtask
  task automatic test_reset();
    int dones = 0;
    #1;
    checks++;
    if ({busy, done, fault, drop_activated, height, t_act, seven_seg1, seven_seg2, seven_seg3, seven_seg4} !== '0) begin
      errors++; $display("FAIL reset_initial: got busy=%b done=%b height=%0d", busy, done, height);
    end
    @(negedge clk); rst_n = 1;
    run_case("pre_reset", {8'd100, 8'd100, 8'd100, 8'd100}, 16'd1280, 1'b1);
    @(negedge clk); sensors = {8'd10, 8'd20, 8'd30, 8'd40}; start = 1;
    @(negedge clk); start = 0;
    repeat (8) @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({busy, done, fault, drop_activated, seven_seg1, seven_seg2, seven_seg3, seven_seg4} !== '0) begin
      errors++; $display("FAIL reset_async: got busy=%b done=%b drop=%b", busy, done, drop_activated);
    end
    @(negedge clk); rst_n = 1;
    repeat (40) begin @(negedge clk); if (done) dones++; end
    checks++; if (dones !== 0) begin errors++; $display("FAIL reset_no_done: got %0d want 0", dones); end
  endtask
  task automatic test_drop();
    run_case("drop", {8'd100, 8'd100, 8'd100, 8'd100}, 16'd1280, 1'b1);
    checks++; if (t_act !== 16'd1280 || drop_activated !== 1'b1) begin
      errors++; $display("FAIL drop_direct: got t=%0d d=%b want 1280/1", t_act, drop_activated);
    end
  endtask
  task automatic test_cold();
    run_case("cold_lim", {8'd100, 8'd100, 8'd100, 8'd100}, 16'd1279, 1'b1);
    run_case("cold_en", {8'd100, 8'd100, 8'd100, 8'd100}, 16'd1280, 1'b0);
    checks++; if ({seven_seg1, seven_seg2, seven_seg3, seven_seg4} !== COLD) begin
      errors++; $display("FAIL cold_direct: got %h want %h", {seven_seg1, seven_seg2, seven_seg3, seven_seg4}, COLD);
    end
  endtask
  task automatic test_rounding();
    run_case("round", {8'd0, 8'd50, 8'd0, 8'd51}, 16'd65535, 1'b1);
    checks++; if (height !== 8'd51 || t_act !== 16'd914) begin
      errors++; $display("FAIL round_direct: got h=%0d t=%0d want 51/914", height, t_act);
    end
  endtask
  task automatic test_fault();
    run_case("fault", 32'd0, 16'd500, 1'b1);
    run_case("fault_clear", {8'd0, 8'd0, 8'd9, 8'd0}, 16'd500, 1'b1);
  endtask
  task automatic test_ignore_start();
    logic ef, ed;
    int eh, et, elat, dones = 0;
    logic [27:0] eseg;
    model({8'd200, 8'd10, 8'd0, 8'd77}, 16'd2000, 1'b1, ef, eh, et, ed, eseg, elat);
    @(negedge clk); sensors = {8'd200, 8'd10, 8'd0, 8'd77}; t_lim = 16'd2000; drop_en = 1; start = 1;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    sensors = {8'd1, 8'd1, 8'd1, 8'd1}; t_lim = 16'd0; drop_en = 0; start = 1;
    @(negedge clk); start = 0;
    repeat (45) begin @(negedge clk); if (done) dones++; end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    checks++; if (int'(height) !== eh || int'(t_act) !== et || drop_activated !== ed) begin
      errors++; $display("FAIL ignore_result: got %0d/%0d/%b want %0d/%0d/%b", height, t_act, drop_activated, eh, et, ed);
    end
    run_case("max", {4{8'd255}}, 16'd2043, 1'b1);
    checks++; if (height !== 8'd255 || t_act !== 16'd2043) begin
      errors++; $display("FAIL max_direct: got h=%0d t=%0d want 255/2043", height, t_act);
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      logic [31:0] sv;
      logic ef, ed;
      int eh, et, elat;
      logic [27:0] eseg;
      for (int i = 0; i < 4; i++) sv[i*8 +: 8] = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
      model(sv, 16'd0, 1'b1, ef, eh, et, ed, eseg, elat);
      run_case("random", sv, ($urandom_range(1) != 0) ? 16'(et + $urandom_range(4) - 2) : 16'($urandom),
               $urandom_range(9) != 0);
    end
  endtask
  task automatic test_back_to_back();
    run_case("b2b_a", {8'd3, 8'd4, 8'd5, 8'd6}, 16'd300, 1'b1);
    run_case("b2b_b", {8'd250, 8'd0, 8'd0, 8'd0}, 16'd2000, 1'b1);
  endtask
  initial begin
    test_reset();
    test_drop();
    test_cold();
    test_rounding();
    test_fault();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
